uart_rom_loader: RTL

Program-download front end for the tinyriscv SoC. It receives a framed binary image over a UART line and writes it, one 32-bit word at a time, into the instruction ROM's write port. While a download is in progress it holds the core in reset, so the core only ever fetches from a fully written image. It sits directly upstream of `rom` and drives the core's reset qualifier.

---
 rtl/uart_loader_pkg.sv | 27 ++
 rtl/uart_rom_loader_if.sv | 11 +
 rtl/uart_rx.sv | 106 ++++++++++
 rtl/uart_rom_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART ROM loader and its receiver.
package uart_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rom_loader_if.sv
// ROM write port driven by the loader (master) and consumed by the ROM (slave).
interface uart_rom_loader_if;

    logic                                rom_we_o;
    logic [uart_loader_pkg::WORD_W-1:0]  rom_waddr_o;
    logic [uart_loader_pkg::WORD_W-1:0]  rom_wdata_o;

    modport master (output rom_we_o, rom_waddr_o, rom_wdata_o);
    modport slave  (input  rom_we_o, rom_waddr_o, rom_wdata_o);

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit start confirm, centre sampling,
// registered byte with a valid pulse or a framing-error pulse.
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              frame_err_o
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_e         state_q, state_d;
    logic              meta_q, sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RX_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (!sync_q) state_d = RX_START;
            RX_START: if (cnt_q == CNT_HALF) state_d = sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_q == CNT_LAST && bit_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (cnt_q == CNT_LAST) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Baud/bit counting and sampling; the stop-bit sample decides valid vs framing error.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: cnt_d = '0;
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[BYTE_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    byte_d  = shift_q;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_rom_loader.sv
// Framed UART image download into instruction ROM, holding the core in reset meanwhile.
// Optional checksum byte and CSUM state: define UART_LOADER_CHECKSUM_EN.
module uart_rom_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned MAX_WORDS      = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_i,
    uart_rom_loader_if.master rom_if,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`ifdef UART_LOADER_CHECKSUM_EN
    localparam loader_state_e POST_DATA = ST_CSUM;
`else
    localparam loader_state_e POST_DATA = ST_DONE;
`endif

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid, rx_ferr;

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [TMO_W-1:0]  timer_q, timer_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif
    logic              rom_we_q, rom_we_d;
    logic [WORD_W-1:0] rom_waddr_q, rom_waddr_d;
    logic [WORD_W-1:0] rom_wdata_q, rom_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              sync_c, in_frame_c, timeout_c, last_word_c;
    logic [LEN_W-1:0]  len_full_c;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (uart_rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    assign sync_c      = rx_valid && (rx_byte == SYNC_BYTE);
    assign in_frame_c  = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                         (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign timeout_c   = in_frame_c && !rx_valid && !rx_ferr && (timer_q == TMO_LAST);
    assign len_full_c  = {rx_byte, len_q[BYTE_W-1:0]};
    assign last_word_c = (word_idx_q == LEN_W'(len_q - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sync_c) state_d = ST_LEN0;
            ST_LEN0: begin
                if (rx_ferr || timeout_c) state_d = ST_ERR;
                else if (rx_valid)        state_d = ST_LEN1;
            end
            ST_LEN1: begin
                if (rx_ferr || timeout_c) state_d = ST_ERR;
                else if (rx_valid) begin
                    if (32'(len_full_c) > MAX_WORDS) state_d = ST_ERR;
                    else if (len_full_c == '0)       state_d = POST_DATA;
                    else                             state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_ferr || timeout_c) state_d = ST_ERR;
                else if (rx_valid && byte_cnt_q == 2'd3 && last_word_c) state_d = POST_DATA;
            end
`ifdef UART_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_ferr || timeout_c) state_d = ST_ERR;
                else if (rx_valid)        state_d = (rx_byte == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  if (sync_c) state_d = ST_LEN0;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs plus the length/word/byte counters, word assembly and idle timer.
    always_comb begin
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
        core_rst_d  = (state_q != ST_IDLE);
        busy_d      = in_frame_c;
        done_d      = (state_q == ST_DONE);
        err_d       = (state_q == ST_ERR);
        timer_d     = (in_frame_c && !rx_valid && !rx_ferr) ? timer_q + TMO_W'(1) : '0;

        if (sync_c && (state_q == ST_IDLE || state_q == ST_ERR)) begin
            len_d      = '0;
            word_idx_d = '0;
            byte_cnt_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end else if (rx_valid) begin
            case (state_q)
                ST_LEN0: len_d[BYTE_W-1:0]       = rx_byte;
                ST_LEN1: len_d[LEN_W-1:BYTE_W]   = rx_byte;
                ST_DATA: begin
                    shift_d    = {rx_byte, shift_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d     = csum_q + rx_byte;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        rom_we_d    = 1'b1;
                        rom_waddr_d = BASE_ADDR + WORD_W'({word_idx_q, 2'b00});
                        rom_wdata_d = {rx_byte, shift_q};
                        word_idx_d  = word_idx_q + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            timer_q     <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
            rom_we_q    <= 1'b0;
            rom_waddr_q <= '0;
            rom_wdata_q <= '0;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            timer_q     <= timer_d;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            rom_we_q    <= rom_we_d;
            rom_waddr_q <= rom_waddr_d;
            rom_wdata_q <= rom_wdata_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rom_if.rom_we_o    = rom_we_q;
    assign rom_if.rom_waddr_o = rom_waddr_q;
    assign rom_if.rom_wdata_o = rom_wdata_q;
    assign core_rst_o         = core_rst_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign err_o              = err_q;

endmodule
